// File: rtl/arf074b032e1r1w0cbbehsaa4acw_wr_ctl_pkg.sv
// arf074b032e1r1w0cbbehsaa4acw_wr_ctl_pkg: shared types, default sizes and the round-robin pick
package arf074b032e1r1w0cbbehsaa4acw_wr_ctl_pkg;

    typedef enum logic {IDLE, SWEEP} state_e;

    localparam int DEF_DATA_W  = 74;
    localparam int DEF_DEPTH   = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_NUM_REQ = 4;

    // One-hot grant: first valid requester at or above ptr, wrapping at n (n <= 8).
    function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        logic [7:0] g;
        logic found;
        int idx;
        g = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && valid[idx]) begin
                g[idx] = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/arf074b032e1r1w0cbbehsaa4acw_ctech_sync.sv
// arf074b032e1r1w0cbbehsaa4acw_ctech_sync: two-flop synchronizer for a single asynchronous level
module arf074b032e1r1w0cbbehsaa4acw_ctech_sync (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic s1_q, s2_q;

    always_ff @(posedge clk) begin
        s1_q <= d;
        s2_q <= s1_q;
    end

    assign q = s2_q;

endmodule

// File: rtl/arf074b032e1r1w0cbbehsaa4acw_wr_ctl.sv
// arf074b032e1r1w0cbbehsaa4acw_wr_ctl: round-robin write-port arbiter with an init clear sweep.
// Define ARF074B032E1R1W0CBBEHSAA4ACW_WR_CTL_AUTO_INIT_EN to start a sweep straight out of reset.
module arf074b032e1r1w0cbbehsaa4acw_wr_ctl
    import arf074b032e1r1w0cbbehsaa4acw_wr_ctl_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                NUM_REQ  = DEF_NUM_REQ,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      init_busy,
    output logic                      init_done
);

    localparam int CNT_W = ADDR_W + 1;

`ifdef ARF074B032E1R1W0CBBEHSAA4ACW_WR_CTL_AUTO_INIT_EN
    localparam state_e RST_STATE = SWEEP;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_e RST_STATE = IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               prev_q;
    logic               init_sync;
    logic               edge_det;
    logic [7:0]         grant;
    logic [2:0]         gnt_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    arf074b032e1r1w0cbbehsaa4acw_ctech_sync u_sync (
        .clk (clk),
        .d   (init_req),
        .q   (init_sync)
    );

    always_comb begin
        edge_det  = init_sync & ~prev_q;
        grant     = rr_pick(8'(req_valid), ptr_q, NUM_REQ);
        req_ready = (state_q == IDLE && !edge_det) ? grant[NUM_REQ-1:0] : '0;
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx  = 3'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            // The edge cycle already issues address 0 so the sweep spans exactly DEPTH cycles.
            if (edge_det) begin
                state_d   = SWEEP;
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = INIT_VAL;
                cnt_d     = CNT_W'(1);
                busy_d    = 1'b1;
            end else if (|req_ready) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr;
                wr_data_d = sel_data;
                ptr_d     = (int'(gnt_idx) == NUM_REQ - 1) ? 3'd0 : gnt_idx + 3'd1;
            end
        end else if (cnt_q == CNT_W'(DEPTH)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
        end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[ADDR_W-1:0];
            wr_data_d = INIT_VAL;
            cnt_d     = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= RST_BUSY;
            done_q    <= 1'b0;
            prev_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            prev_q    <= init_sync;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign init_busy = busy_q;
    assign init_done = done_q;

endmodule

// File: doc/arf074b032e1r1w0cbbehsaa4acw_wr_ctl.md
Name: arf074b032e1r1w0cbbehsaa4acw_wr_ctl

Overview:
Write-port controller for the 74-bit x 32-entry 1R1W register array. It shares the single write port between NUM_REQ requesters using round-robin arbitration with a valid/ready handshake. It also runs a clear sweep that writes INIT_VAL to every entry when triggered by an asynchronous init request. The block sits directly in front of the array write port, in the array's clock domain.

Parameters:
DATA_W, 74, write data width
DEPTH, 32, number of array entries
ADDR_W, 5, address width, equal to $clog2(DEPTH)
NUM_REQ, 4, number of write requesters (2..8)
INIT_VAL, '0, DATA_W-bit value written by the sweep

Ports:
clk  input  1  array clock; the only clock
rst  input  1  synchronous, active-high reset
init_req  input  1  asynchronous clear request; a 0->1 transition starts a sweep
req_valid  input  NUM_REQ  per-requester write valid
req_addr  input  NUM_REQ*ADDR_W  per-requester address; slice i belongs to requester i
req_data  input  NUM_REQ*DATA_W  per-requester data; slice i belongs to requester i
req_ready  output  NUM_REQ  grant; a transfer occurs when valid and ready are both 1
wr_en  output  1  array write enable (registered)
wr_addr  output  ADDR_W  array write address (registered)
wr_data  output  DATA_W  array write data (registered)
init_busy  output  1  high while a sweep is in progress
init_done  output  1  one-cycle pulse after the last sweep write

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, init_busy=0, init_done=0, round-robin pointer=0, sweep counter=0, state=IDLE.
- init_req passes through the array's ctech_sync double-sync cell, which adds 2 cycles.
- Edge detect: a prev register holds the last synced value and resets to 1. A level held high through reset therefore does not trigger a sweep; only a 0->1 transition after reset does.
- FSM states:
  - IDLE: arbitrate requesters.
  - SWEEP: issue clear writes.
- IDLE -> SWEEP on a detected edge. That cycle no grant is issued and req_ready=0.
- SWEEP -> IDLE after the write to address DEPTH-1 has been issued.
- SWEEP: one write per cycle; wr_en=1, wr_addr=counter, wr_data=INIT_VAL, counter increments.
  - init_busy=1 from the cycle after the edge through the last sweep write.
  - init_done pulses on the cycle after the last write.
  - req_ready=0 for the whole sweep.
  - A sweep takes exactly DEPTH cycles.
- Edges during SWEEP are ignored; the sweep is not restarted. An edge arriving after the return to IDLE starts a new sweep.
- Arbitration (IDLE only):
  - req_ready is combinational and one-hot: the first requester with valid=1, searching from the pointer upward and wrapping at NUM_REQ.
  - After a grant to requester i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Write latency: a handshake in cycle N produces wr_en=1 with that requester's addr/data in cycle N+1. Without a handshake, wr_en=0 and wr_addr/wr_data hold their last values.
- Requesters must hold addr/data stable while valid=1 and ready=0. Dropping valid before the handshake is legal.
- Reset asserted mid-sweep aborts the sweep: every output and the counter return to their reset values, and no init_done pulse is produced.

Optional Feature:
Macro ARF074B032E1R1W0CBBEHSAA4ACW_WR_CTL_AUTO_INIT_EN
- Defined: the FSM leaves reset in SWEEP with init_busy=1. The first cycle after rst deasserts writes address 0, and init_done pulses after DEPTH writes. req_ready=0 until then.
- Undefined: the block leaves reset in IDLE and sweeps only on an init_req edge.

Decomposition:
- Package arf074b032e1r1w0cbbehsaa4acw_wr_ctl_pkg holds:
  - state enum {IDLE, SWEEP};
  - the default DATA_W, DEPTH, ADDR_W and NUM_REQ localparams;
  - the round-robin pick function (one-hot result from valid and pointer).
- One sub-module: the existing arf074b032e1r1w0cbbehsaa4acw_ctech_sync on init_req. No other hierarchy.

Test Plan:
- Macro undefined, rst for 3 cycles then released, init_req pulsed 0->1 -> init_busy rises 3 cycles later; 32 consecutive wr_en with wr_addr 0..31 and wr_data=0; init_done pulses once; req_ready=0 throughout.
- All 4 req_valid=1 continuously after reset -> grants in order 0,1,2,3,0,... ; each wr_en is one cycle after its grant with matching addr/data (e.g. req2 addr=5'h1A, data=74'h3FF lands at cycle N+1).
- Only req3 valid, then req1 and req3 valid -> req3 granted, pointer wraps to 0, next grant req1.
- init_req edge arrives in the same cycle as req0 valid -> no grant that cycle; sweep runs; req0 granted on the first IDLE cycle after init_done.
- rst asserted at sweep address 10 -> next cycle wr_en=0, init_busy=0, no init_done; after release in IDLE (macro undefined), init_req held high produces no sweep.
- Macro defined, reset released -> wr_en=1 at wr_addr=0 in the first cycle; 32 writes, then init_done; a second init_req edge starts a second 32-write sweep.
